vga_sync_rx: RTL

VGA_SYNC_RX -- requirements
Module: vga_sync_rx

---
 rtl/vga_sync_rx.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/vga_sync_rx.sv
// ============================================================================
// Module      : vga_sync_rx
// Description : Recovers x/y position, line/frame length and lock state from
//               incoming VGA hsync/vsync. Optional two-stage input
//               synchronizer enabled by VGA_SYNC_RX_SYNC_STAGES_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_sync_rx #(
  parameter int H_START     = 144,
  parameter int H_ACTIVE    = 640,
  parameter int V_START     = 35,
  parameter int V_ACTIVE    = 480,
  parameter int HS_POL      = 1,
  parameter int VS_POL      = 0,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       hs_in,
  input  logic       vs_in,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic [9:0] h_total,
  output logic [9:0] v_total,
  output logic       locked,
  output logic       err
);

  localparam logic       HS_LVL = (HS_POL != 0);
  localparam logic       VS_LVL = (VS_POL != 0);
  localparam logic [10:0] X_LO  = 11'(H_START);
  localparam logic [10:0] X_HI  = 11'(H_START + H_ACTIVE);
  localparam logic [10:0] Y_LO  = 11'(V_START);
  localparam logic [10:0] Y_HI  = 11'(V_START + V_ACTIVE);
  localparam logic [2:0]  LOCK_N = 3'(LOCK_FRAMES);
  localparam logic [9:0]  CNT_MAX = 10'd1023;
  localparam logic [9:0]  CNT_PRE = 10'd1022;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic hs_s, vs_s;

`ifdef VGA_SYNC_RX_SYNC_STAGES_EN
  logic [1:0] hs_sync_q, vs_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_sync_q <= {2{~HS_LVL}};
      vs_sync_q <= {2{~VS_LVL}};
    end else begin
      hs_sync_q <= {hs_sync_q[0], hs_in};
      vs_sync_q <= {vs_sync_q[0], vs_in};
    end
  end

  assign hs_s = hs_sync_q[1];
  assign vs_s = vs_sync_q[1];
`else
  assign hs_s = hs_in;
  assign vs_s = vs_in;
`endif

  logic       hs_prev_q, vs_prev_q;
  logic [9:0] x_q, x_d, y_q, y_d;
  logic [9:0] h_total_q, h_total_d, v_total_q, v_total_d;
  logic       vs_pend_q, vs_pend_d;
  logic       line_bad_q, line_bad_d;
  logic [2:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  state_t     state_q, state_d;

  logic       hs_edge, vs_edge, frame_evt, timeout, mismatch;
  logic       h_match, v_match, frame_ok;
  logic [9:0] x_inc, y_inc;
  logic [2:0] cnt_inc;

  assign hs_edge   = (hs_s == HS_LVL) && (hs_prev_q != HS_LVL);
  assign vs_edge   = (vs_s == VS_LVL) && (vs_prev_q != VS_LVL);
  assign x_inc     = x_q + 10'd1;
  assign y_inc     = y_q + 10'd1;
  assign cnt_inc   = cnt_q + 3'd1;
  assign h_match   = (x_inc == h_total_q);
  assign v_match   = (y_inc == v_total_q);
  // A pending vsync is resolved by the next hsync leading edge.
  assign frame_evt = hs_edge && (vs_pend_q || vs_edge);
  assign timeout   = !hs_edge && (x_q == CNT_PRE);
  // The line closed by this boundary edge counts toward the frame verdict.
  assign frame_ok  = v_match && h_match && !line_bad_q;

  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    h_total_d  = h_total_q;
    v_total_d  = v_total_q;
    vs_pend_d  = vs_pend_q;
    line_bad_d = line_bad_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    mismatch   = 1'b0;

    if (hs_edge) begin
      x_d = 10'd0;
    end else if (x_q != CNT_MAX) begin
      x_d = x_inc;
    end

    if (vs_edge) begin
      vs_pend_d = 1'b1;
    end

    if (hs_edge) begin
      h_total_d = x_inc;
      if (!h_match) begin
        line_bad_d = 1'b1;
      end
      if (frame_evt) begin
        y_d        = 10'd0;
        v_total_d  = y_inc;
        vs_pend_d  = 1'b0;
        line_bad_d = 1'b0;
      end else if (y_q != CNT_MAX) begin
        y_d = y_inc;
      end
    end

    case (state_q)
      ST_SEARCH: begin
        if (frame_evt) begin
          state_d = ST_CHECK;
          cnt_d   = 3'd0;
        end
      end
      ST_CHECK: begin
        if (frame_evt) begin
          if (!frame_ok) begin
            cnt_d = 3'd0;
          end else if (cnt_inc >= LOCK_N) begin
            state_d = ST_LOCKED;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      ST_LOCKED: begin
        if ((hs_edge && !h_match) || (frame_evt && !v_match)) begin
          mismatch = 1'b1;
          state_d  = ST_SEARCH;
        end
      end
      default: state_d = ST_SEARCH;
    endcase

    if (timeout) begin
      state_d = ST_SEARCH;
      cnt_d   = 3'd0;
    end

    err_d = timeout || mismatch;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hs_prev_q  <= ~HS_LVL;
      vs_prev_q  <= ~VS_LVL;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      h_total_q  <= 10'd0;
      v_total_q  <= 10'd0;
      vs_pend_q  <= 1'b0;
      line_bad_q <= 1'b0;
      cnt_q      <= 3'd0;
      err_q      <= 1'b0;
      state_q    <= ST_SEARCH;
    end else begin
      hs_prev_q  <= hs_s;
      vs_prev_q  <= vs_s;
      x_q        <= x_d;
      y_q        <= y_d;
      h_total_q  <= h_total_d;
      v_total_q  <= v_total_d;
      vs_pend_q  <= vs_pend_d;
      line_bad_q <= line_bad_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      state_q    <= state_d;
    end
  end

  assign x       = x_q;
  assign y       = y_q;
  assign h_total = h_total_q;
  assign v_total = v_total_q;
  assign err     = err_q;
  assign locked  = (state_q == ST_LOCKED);
  assign active  = locked
                && ({1'b0, x_q} >= X_LO) && ({1'b0, x_q} < X_HI)
                && ({1'b0, y_q} >= Y_LO) && ({1'b0, y_q} < Y_HI);

endmodule

`default_nettype wire
